// File: rtl/cpu_defs.sv
// Shared execute-stage definitions: default datapath width and divider state encoding.
package cpu_defs;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift {rem, dividend} left, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] dvd_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem_i, dvd_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_i};

    // A clear borrow bit means the trial subtraction fits: keep it and emit a 1.
    assign rem_o = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign dvd_o = {dvd_i[WIDTH-2:0], ~diff[WIDTH]};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU; stalls F/D/E while iterating and
// delivers {remainder, quotient} for the HI/LO write.
module div_unit
    import cpu_defs::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_div,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 stall_div,
    output logic                 ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   dvd_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               qneg_q;
    logic               rneg_q;
    logic               dz_q;
    logic               ready_q;
    logic [2*WIDTH-1:0] result_q;

    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   dvd_d;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .dvd_i (dvd_q),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .dvd_o (dvd_d)
    );

    // Divide-by-zero forces an all-ones quotient regardless of operand signs.
    assign quo_fix = dz_q   ? '1     : (qneg_q ? -dvd_q : dvd_q);
    assign rem_fix = rneg_q ? -rem_q : rem_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else begin
            ready_q <= 1'b0;
            if (annul) begin
                state_q <= DIV_IDLE;
            end else begin
                case (state_q)
                    DIV_IDLE: begin
                        if (start) begin
                            dvd_q   <= magnitude(a, signed_div);
                            dvs_q   <= magnitude(b, signed_div);
                            qneg_q  <= (a[WIDTH-1] ^ b[WIDTH-1]) & signed_div;
                            rneg_q  <= a[WIDTH-1] & signed_div;
                            dz_q    <= (b == '0);
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= DIV_BUSY;
                        end
                    end
                    DIV_BUSY: begin
                        rem_q <= rem_d;
                        dvd_q <= dvd_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
                            state_q <= DIV_DONE;
                        end
                    end
                    DIV_DONE: begin
                        // start is still the same instruction's divE here, so it is ignored.
                        result_q <= {rem_fix, quo_fix};
                        ready_q  <= 1'b1;
                        state_q  <= DIV_IDLE;
                    end
                    default: begin
                        state_q <= DIV_IDLE;
                    end
                endcase
            end
        end
    end

    // Stall drops in DONE so the instruction leaves E together with the result write.
    assign stall_div = ~annul & (((state_q == DIV_IDLE) & start) | (state_q == DIV_BUSY));
    assign ready     = ready_q;
    assign result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit with an expected-result queue popped on each ready pulse.
module tb_div_unit;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic           signed_div;
    logic           annul;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           stall_div;
    logic           ready;
    logic [2*W-1:0] result;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];
    longint      t1, t2, t_dummy;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .annul      (annul),
        .a          (a),
        .b          (b),
        .stall_div  (stall_div),
        .ready      (ready),
        .result     (result)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Issue one division, hold start while stalled, drop it after the DONE cycle.
    task automatic run_div(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic sg, input logic [63:0] expv, output longint t_ready);
        int          stalls;
        bit          drop;
        bit          done;
        logic [63:0] e;
        stalls  = 0;
        drop    = 0;
        done    = 0;
        t_ready = 0;
        @(posedge clk); #1;
        a = av; b = bv; signed_div = sg; start = 1'b1;
        exp_q.push_back(expv);
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) check({tag, "_ready_low"}, {63'b0, ready}, 64'd0);
            if (ready) begin
                e = exp_q.pop_front();
                check({tag, "_result"},  result, e);
                check({tag, "_latency"}, 64'(cyc), 64'd34);
                check({tag, "_stalls"},  64'(stalls), 64'd33);
                t_ready = $time;
                done    = 1;
            end else begin
                if (stall_div) stalls++;
                else if (start) drop = 1;
                @(posedge clk); #1;
                if (drop) start = 1'b0;
                if (cyc == 2) begin
                    a = $urandom;
                    b = $urandom;
                end
            end
        end
        check({tag, "_completed"}, {63'b0, done}, 64'd1);
        start = 1'b0;
    endtask

    initial begin
        int pulses;
        int stall_seen;

        rst = 1'b0; start = 1'b0; signed_div = 1'b0; annul = 1'b0; a = '0; b = '0;
        #12;
        check("reset_result", result, 64'd0);
        check("reset_ready",  {63'b0, ready}, 64'd0);
        check("reset_stall",  {63'b0, stall_div}, 64'd0);
        @(negedge clk); rst = 1'b1;

        run_div("udiv_100_7",  32'd100,        32'd7,          1'b0, {32'h00000002, 32'h0000000E}, t_dummy);
        run_div("sdiv_m7_2",   32'hFFFFFFF9,   32'd2,          1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, t_dummy);
        run_div("sdiv_7_m2",   32'd7,          32'hFFFFFFFE,   1'b1, {32'h00000001, 32'hFFFFFFFD}, t_dummy);
        run_div("udiv_zero",   32'h12345678,   32'h0,          1'b0, {32'h12345678, 32'hFFFFFFFF}, t_dummy);
        run_div("sdiv_zero",   32'h12345678,   32'h0,          1'b1, {32'h12345678, 32'hFFFFFFFF}, t_dummy);
        run_div("sdiv_ovf",    32'h80000000,   32'hFFFFFFFF,   1'b1, {32'h00000000, 32'h80000000}, t_dummy);

        // Annul in BUSY cycle 10: no result, back to IDLE, result held.
        @(posedge clk); #1;
        a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
        repeat (10) @(posedge clk);
        #1 annul = 1'b1;
        @(negedge clk);
        check("annul_stall_low", {63'b0, stall_div}, 64'd0);
        check("annul_ready_low", {63'b0, ready}, 64'd0);
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        pulses = 0; stall_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) pulses++;
            if (stall_div) stall_seen++;
        end
        check("annul_no_ready",    64'(pulses), 64'd0);
        check("annul_idle",        64'(stall_seen), 64'd0);
        check("annul_result_hold", result, {32'h00000000, 32'h80000000});

        // Asynchronous reset mid-BUSY.
        @(posedge clk); #1;
        a = 32'd50; b = 32'd5; signed_div = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_result", result, 64'd0);
        check("async_rst_stall",  {63'b0, stall_div}, 64'd0);
        check("async_rst_ready",  {63'b0, ready}, 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        run_div("post_rst_9_3", 32'd9, 32'd3, 1'b0, {32'h00000000, 32'h00000003}, t_dummy);

        // Back-to-back: the second start arrives the cycle after the first ready.
        run_div("b2b_first",  32'hFFFFFFFF, 32'h00000010, 1'b0, {32'h0000000F, 32'h0FFFFFFF}, t1);
        run_div("b2b_second", 32'hFFFFFF9C, 32'd7,        1'b1, {32'hFFFFFFFE, 32'hFFFFFFF2}, t2);
        check("b2b_gap", 64'((t2 - t1) / 10), 64'd35);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
